// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS preset countdown in centiseconds with a six-digit
// active-low 7-segment display. key0 starts/pauses, key1 loads the preset,
// and done is raised once the count has decremented to 00:00.00.
module countdown_timer #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key0_in,
  input  logic       key1_in,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [6:0] min1,
  output logic [6:0] min2,
  output logic [6:0] sec1,
  output logic [6:0] sec2,
  output logic [6:0] ms1,
  output logic [6:0] ms2,
  output logic       running,
  output logic       done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;

  logic [3:0] min_t, min_u, sec_t, sec_u, cs_t, cs_u;
  logic [3:0] dec_min_t, dec_min_u, dec_sec_t, dec_sec_u, dec_cs_t, dec_cs_u;
  logic [3:0] ld_min_t, ld_min_u, ld_sec_t, ld_sec_u;

  logic k0_meta, k0_sync, k0_prev;
  logic k1_meta, k1_sync, k1_prev;
  logic key0_press, key1_press;
  logic count_zero, count_one, tick;

  // Two-flop synchronizers plus a delayed copy for falling-edge detection;
  // keys idle high, so everything resets to 1 to avoid a phantom press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k0_meta <= 1'b1;
      k0_sync <= 1'b1;
      k0_prev <= 1'b1;
      k1_meta <= 1'b1;
      k1_sync <= 1'b1;
      k1_prev <= 1'b1;
    end else begin
      k0_meta <= key0_in;
      k0_sync <= k0_meta;
      k0_prev <= k0_sync;
      k1_meta <= key1_in;
      k1_sync <= k1_meta;
      k1_prev <= k1_sync;
    end
  end

  assign key0_press = k0_prev & ~k0_sync;
  assign key1_press = k1_prev & ~k1_sync;

  assign count_zero = (min_t == 4'd0) && (min_u == 4'd0) && (sec_t == 4'd0) &&
                      (sec_u == 4'd0) && (cs_t == 4'd0) && (cs_u == 4'd0);
  assign count_one  = (min_t == 4'd0) && (min_u == 4'd0) && (sec_t == 4'd0) &&
                      (sec_u == 4'd0) && (cs_t == 4'd0) && (cs_u == 4'd1);
  assign tick       = (state == S_RUN) && (presc == PRESC_LAST);

  // Preset digits clamped to legal BCD; seconds tens never exceeds 5.
  always_comb begin
    ld_min_t = (preset_min[7:4] > 4'd9) ? 4'd9 : preset_min[7:4];
    ld_min_u = (preset_min[3:0] > 4'd9) ? 4'd9 : preset_min[3:0];
    ld_sec_t = (preset_sec[7:4] > 4'd5) ? 4'd5 : preset_sec[7:4];
    ld_sec_u = (preset_sec[3:0] > 4'd9) ? 4'd9 : preset_sec[3:0];
  end

  // One-centisecond BCD decrement; each digit borrows from the next only
  // when every lower digit wraps.
  always_comb begin
    dec_min_t = min_t;
    dec_min_u = min_u;
    dec_sec_t = sec_t;
    dec_sec_u = sec_u;
    dec_cs_t  = cs_t;
    dec_cs_u  = cs_u;
    if (cs_u != 4'd0) begin
      dec_cs_u = cs_u - 4'd1;
    end else begin
      dec_cs_u = 4'd9;
      if (cs_t != 4'd0) begin
        dec_cs_t = cs_t - 4'd1;
      end else begin
        dec_cs_t = 4'd9;
        if (sec_u != 4'd0) begin
          dec_sec_u = sec_u - 4'd1;
        end else begin
          dec_sec_u = 4'd9;
          if (sec_t != 4'd0) begin
            dec_sec_t = sec_t - 4'd1;
          end else begin
            dec_sec_t = 4'd5;
            if (min_u != 4'd0) begin
              dec_min_u = min_u - 4'd1;
            end else begin
              dec_min_u = 4'd9;
              dec_min_t = (min_t != 4'd0) ? (min_t - 4'd1) : 4'd9;
            end
          end
        end
      end
    end
  end

  // Control FSM: owns the state, prescaler, count digits and status flags.
  // A key0 press is checked before the tick so a simultaneous press pauses
  // without decrementing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      presc   <= '0;
      min_t   <= 4'd0;
      min_u   <= 4'd0;
      sec_t   <= 4'd0;
      sec_u   <= 4'd0;
      cs_t    <= 4'd0;
      cs_u    <= 4'd0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key1_press) begin
            min_t <= ld_min_t;
            min_u <= ld_min_u;
            sec_t <= ld_sec_t;
            sec_u <= ld_sec_u;
            cs_t  <= 4'd0;
            cs_u  <= 4'd0;
          end else if (key0_press && !count_zero) begin
            state   <= S_RUN;
            presc   <= '0;
            running <= 1'b1;
          end
        end
        S_RUN: begin
          if (key0_press) begin
            state   <= S_IDLE;
            presc   <= '0;
            running <= 1'b0;
          end else if (tick) begin
            presc <= '0;
            min_t <= dec_min_t;
            min_u <= dec_min_u;
            sec_t <= dec_sec_t;
            sec_u <= dec_sec_u;
            cs_t  <= dec_cs_t;
            cs_u  <= dec_cs_u;
            if (count_one) begin
              state   <= S_DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        S_DONE: begin
          if (key1_press) begin
            min_t <= ld_min_t;
            min_u <= ld_min_u;
            sec_t <= ld_sec_t;
            sec_u <= ld_sec_u;
            cs_t  <= 4'd0;
            cs_u  <= 4'd0;
            state <= S_IDLE;
            done  <= 1'b0;
          end else if (key0_press) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign min1 = seg7(min_t);
  assign min2 = seg7(min_u);
  assign sec1 = seg7(sec_t);
  assign sec2 = seg7(sec_u);
  assign ms1  = seg7(cs_t);
  assign ms2  = seg7(cs_u);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed testbench for countdown_timer with CLK_HZ=1000, TICK_HZ=100,
// giving a ten-cycle tick period.
module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic       key0_in;
  logic       key1_in;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic [6:0] min1, min2, sec1, sec2, ms1, ms2;
  logic       running;
  logic       done;

  int total_checks;
  int bad_checks;

  countdown_timer #(
    .CLK_HZ (1000),
    .TICK_HZ(100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key0_in   (key0_in),
    .key1_in   (key1_in),
    .preset_min(preset_min),
    .preset_sec(preset_sec),
    .min1      (min1),
    .min2      (min2),
    .sec1      (sec1),
    .sec2      (sec2),
    .ms1       (ms1),
    .ms2       (ms2),
    .running   (running),
    .done      (done)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    logic [6:0] table_v [10];
    table_v[0] = 7'b1000000;
    table_v[1] = 7'b1111001;
    table_v[2] = 7'b0100100;
    table_v[3] = 7'b0110000;
    table_v[4] = 7'b0011001;
    table_v[5] = 7'b0010010;
    table_v[6] = 7'b0000010;
    table_v[7] = 7'b1111000;
    table_v[8] = 7'b0000000;
    table_v[9] = 7'b0010000;
    return (d <= 4'd9) ? table_v[d] : 7'b1111111;
  endfunction

  // Expected six-digit segment image for a count written as 24'hMMSSCC
  function automatic logic [41:0] ref_disp(input logic [23:0] bcd);
    return {ref_seg(bcd[23:20]), ref_seg(bcd[19:16]), ref_seg(bcd[15:12]),
            ref_seg(bcd[11:8]), ref_seg(bcd[7:4]), ref_seg(bcd[3:0])};
  endfunction

  function automatic logic [41:0] seen_disp();
    return {min1, min2, sec1, sec2, ms1, ms2};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the chosen keys low for three sampling edges, then release; the
  // press takes effect on the third edge, and the task returns 1 after it.
  task automatic applyStimulus(input logic k0, input logic k1);
    @(posedge clk);
    #1;
    key0_in = ~k0;
    key1_in = ~k1;
    repeat (3) @(posedge clk);
    #1;
    key0_in = 1'b1;
    key1_in = 1'b1;
  endtask

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    rst        = 1'b0;
    key0_in    = 1'b1;
    key1_in    = 1'b1;
    preset_min = 8'h00;
    preset_sec = 8'h00;

    // Reset values visible before the first clock edge
    #3;
    checkOutput("reset_disp", 64'(seen_disp()), 64'(ref_disp(24'h000000)));
    checkOutput("reset_flags", 64'({running, done}), 64'(2'b00));
    #9;
    rst = 1'b1;
    waitCycles(3);

    $display("[TB] start at zero is ignored");
    applyStimulus(1'b1, 1'b0);
    waitCycles(5);
    checkOutput("zero_start_run", 64'(running), 64'(1'b0));
    checkOutput("zero_start_disp", 64'(seen_disp()), 64'(ref_disp(24'h000000)));

    $display("[TB] load 00:01 and run to zero");
    preset_min = 8'h00;
    preset_sec = 8'h01;
    applyStimulus(1'b0, 1'b1);
    checkOutput("load_0001", 64'(seen_disp()), 64'(ref_disp(24'h000100)));
    applyStimulus(1'b1, 1'b0);
    checkOutput("run_flag", 64'({running, done}), 64'(2'b10));
    waitCycles(9);
    checkOutput("before_tick1", 64'(seen_disp()), 64'(ref_disp(24'h000100)));
    waitCycles(1);
    checkOutput("tick1", 64'(seen_disp()), 64'(ref_disp(24'h000099)));
    waitCycles(989);
    checkOutput("cycle999", 64'(seen_disp()), 64'(ref_disp(24'h000001)));
    checkOutput("cycle999_flags", 64'({running, done}), 64'(2'b10));
    waitCycles(1);
    checkOutput("cycle1000", 64'(seen_disp()), 64'(ref_disp(24'h000000)));
    checkOutput("done_flags", 64'({running, done}), 64'(2'b01));
    waitCycles(20);
    checkOutput("done_hold", 64'(seen_disp()), 64'(ref_disp(24'h000000)));
    applyStimulus(1'b1, 1'b0);
    checkOutput("done_to_idle", 64'({running, done}), 64'(2'b00));

    $display("[TB] borrow chain from 10:00.00");
    preset_min = 8'h10;
    preset_sec = 8'h00;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    waitCycles(10);
    checkOutput("borrow_disp", 64'(seen_disp()), 64'(ref_disp(24'h095999)));
    checkOutput("borrow_sec1", 64'(sec1), 64'(7'b0010010));
    checkOutput("borrow_min2", 64'(min2), 64'(7'b0010000));
    applyStimulus(1'b1, 1'b0);
    checkOutput("borrow_pause", 64'(running), 64'(1'b0));

    $display("[TB] pause and resume");
    preset_min = 8'h00;
    preset_sec = 8'h01;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    waitCycles(35);
    checkOutput("run35", 64'(seen_disp()), 64'(ref_disp(24'h000097)));
    applyStimulus(1'b1, 1'b0);
    checkOutput("paused_flag", 64'(running), 64'(1'b0));
    waitCycles(50);
    checkOutput("paused_hold", 64'(seen_disp()), 64'(ref_disp(24'h000097)));
    applyStimulus(1'b1, 1'b0);
    waitCycles(9);
    checkOutput("resume_9", 64'(seen_disp()), 64'(ref_disp(24'h000097)));
    waitCycles(1);
    checkOutput("resume_10", 64'(seen_disp()), 64'(ref_disp(24'h000096)));

    $display("[TB] load key ignored while running");
    applyStimulus(1'b0, 1'b1);
    checkOutput("run_load_disp", 64'(seen_disp()), 64'(ref_disp(24'h000096)));
    checkOutput("run_load_flag", 64'(running), 64'(1'b1));

    // Four cycles since the last tick; align the pause with the next tick
    $display("[TB] pause on a tick edge");
    waitCycles(2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("tick_pause_disp", 64'(seen_disp()), 64'(ref_disp(24'h000096)));
    checkOutput("tick_pause_flag", 64'(running), 64'(1'b0));

    $display("[TB] reset while running");
    applyStimulus(1'b1, 1'b0);
    waitCycles(4);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_run_disp", 64'(seen_disp()), 64'(ref_disp(24'h000000)));
    checkOutput("rst_run_flags", 64'({running, done}), 64'(2'b00));
    #4;
    rst = 1'b1;
    waitCycles(3);
    applyStimulus(1'b1, 1'b0);
    waitCycles(12);
    checkOutput("rst_no_start", 64'(running), 64'(1'b0));
    checkOutput("rst_no_count", 64'(seen_disp()), 64'(ref_disp(24'h000000)));

    $display("[TB] preset clamping");
    preset_min = 8'hAB;
    preset_sec = 8'h7C;
    applyStimulus(1'b0, 1'b1);
    checkOutput("clamp_load", 64'(seen_disp()), 64'(ref_disp(24'h995900)));

    $display("[TB] load from DONE and simultaneous keys in IDLE");
    preset_min = 8'h00;
    preset_sec = 8'h01;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    waitCycles(1000);
    checkOutput("done_again", 64'(done), 64'(1'b1));
    preset_sec = 8'h02;
    applyStimulus(1'b0, 1'b1);
    checkOutput("done_load_disp", 64'(seen_disp()), 64'(ref_disp(24'h000200)));
    checkOutput("done_load_flags", 64'({running, done}), 64'(2'b00));
    preset_sec = 8'h03;
    applyStimulus(1'b1, 1'b1);
    waitCycles(3);
    checkOutput("both_idle_disp", 64'(seen_disp()), 64'(ref_disp(24'h000300)));
    checkOutput("both_idle_flag", 64'(running), 64'(1'b0));

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
